fastram_cycle_ctrl: RTL

//  Bus-cycle sequencer for the 68030-side fast RAM. It sits between the 030 bus (AS20/DS20/RW20/CBREQ)
//  and the fast RAM chip-select decode. It inserts programmable wait states, returns STERM, and runs
//  4-beat cache-line bursts. It also drives the low longword address (RA[3:2]) and a RAM enable that

---
 rtl/fastram_cycle_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/fastram_cycle_ctrl.sv
// Fast RAM bus-cycle sequencer for the 68030: wait states, STERM, RA and RAM enable.
// Cache-line bursts (CBREQ/CBACK, 4 beats) are compiled in only when FASTRAM_BURST_EN is defined.
module fastram_cycle_ctrl #(
  parameter int WAIT_STATES = 1
) (
  input  logic       CLKCPU,
  input  logic       RESET,
  input  logic       ACCESS,
  input  logic       AS20,
  input  logic       DS20,
  input  logic       RW20,
  input  logic [1:0] A,
  input  logic       CBREQ,
  output logic       STERM,
  output logic       CBACK,
  output logic       RAM_EN,
  output logic [1:0] RA,
  output logic       BUSY
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_HOLD} state_t;

  localparam logic [2:0] WS = 3'(WAIT_STATES);
  // With no wait states every beat goes straight to ACK.
  localparam state_t BEAT_START = (WAIT_STATES == 0) ? S_ACK : S_WAIT;

  state_t     state_reg, state_next;
  logic [2:0] wcnt_reg, wcnt_next;
  logic [1:0] ra_reg, ra_next;
  logic       start;
  logic       last_beat;

`ifdef FASTRAM_BURST_EN
  logic [1:0] bcnt_reg, bcnt_next;
  logic       burst_reg, burst_next;

  assign last_beat = ~burst_reg | (bcnt_reg == 2'd3);
`else
  logic unused_cbreq;

  assign last_beat    = 1'b1;
  assign unused_cbreq = CBREQ;
`endif

  // Writes must wait for the data strobe before the cycle is taken.
  assign start = ~AS20 & ~ACCESS & (RW20 | ~DS20);

  always_ff @(posedge CLKCPU or negedge RESET) begin
    if (!RESET) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (start) state_next = BEAT_START;
      S_WAIT: begin
        if (AS20)                 state_next = S_IDLE;
        else if (wcnt_reg <= 3'd1) state_next = S_ACK;
      end
      S_ACK: begin
        if (AS20)           state_next = S_IDLE;
        else if (last_beat) state_next = S_HOLD;
        else                state_next = BEAT_START;
      end
      S_HOLD: if (AS20) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    wcnt_next = wcnt_reg;
    ra_next   = ra_reg;
`ifdef FASTRAM_BURST_EN
    bcnt_next  = bcnt_reg;
    burst_next = burst_reg;
`endif
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          wcnt_next = WS;
          ra_next   = A;
`ifdef FASTRAM_BURST_EN
          bcnt_next  = 2'd0;
          burst_next = ~CBREQ;
`endif
        end
      end
      S_WAIT: if (!AS20) wcnt_next = wcnt_reg - 3'd1;
      S_ACK: begin
        if (!AS20 && !last_beat) begin
          wcnt_next = WS;
          ra_next   = ra_reg + 2'd1;
`ifdef FASTRAM_BURST_EN
          bcnt_next = bcnt_reg + 2'd1;
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLKCPU or negedge RESET) begin
    if (!RESET) begin
      wcnt_reg <= 3'd0;
      ra_reg   <= 2'd0;
`ifdef FASTRAM_BURST_EN
      bcnt_reg  <= 2'd0;
      burst_reg <= 1'b0;
`endif
    end else begin
      wcnt_reg <= wcnt_next;
      ra_reg   <= ra_next;
`ifdef FASTRAM_BURST_EN
      bcnt_reg  <= bcnt_next;
      burst_reg <= burst_next;
`endif
    end
  end

  always_comb begin
    STERM  = (state_reg != S_ACK);
    BUSY   = (state_reg != S_IDLE);
    RAM_EN = (state_reg == S_IDLE);
    RA     = (state_reg == S_IDLE) ? A : ra_reg;
`ifdef FASTRAM_BURST_EN
    // Burst acknowledge covers every beat except the last one.
    CBACK = ~(burst_reg && (state_reg == S_WAIT || state_reg == S_ACK) && bcnt_reg != 2'd3);
`else
    CBACK = 1'b1;
`endif
  end

endmodule
